// File: rtl/alu_mdu_seq.sv
// Sequential RV32IM-style ALU with iterative multiply and restoring divide.
// Valid/ready on both sides; base ops retire in one registered cycle.
`timescale 1ns/1ps
module alu_mdu_seq #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic [5:0]      SELECT,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY
);
  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0] MUL_LAST = SW'(XLEN/MUL_BITS-1);
  localparam logic [SW-1:0] DIV_LAST = SW'(XLEN-1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [SW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   mplier;
  logic              mul_hi, mplier_neg;
  logic [XLEN-1:0]   quo, rem, dvsr;
  logic              neg_q, neg_r, is_rem;

  assign IN_READY  = (state == IDLE);
  assign BUSY      = (state != IDLE);
  assign OUT_VALID = (state == DONE);

  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] base;
  assign shamt = DATA2[SW-1:0];

  always_comb begin
    base = '0;
    if (SELECT[5:3] == 3'b011) base = DATA2;
    else begin
      case (SELECT)
        6'b000000: base = DATA1 + DATA2;
        6'b000001: base = DATA1 << shamt;
        6'b000010: base = {{(XLEN-1){1'b0}}, $signed(DATA1) < $signed(DATA2)};
        6'b000011: base = {{(XLEN-1){1'b0}}, DATA1 < DATA2};
        6'b000100: base = DATA1 ^ DATA2;
        6'b000101: base = DATA1 >> shamt;
        6'b000110: base = DATA1 | DATA2;
        6'b000111: base = DATA1 & DATA2;
        6'b010000: base = DATA1 - DATA2;
        6'b010101: base = $signed(DATA1) >>> shamt;
        default:   base = '0;
      endcase
    end
  end

  logic is_mul, is_div, sgn, div_zero, div_ovf;
  logic [XLEN-1:0] fast_res, a_mag, b_mag;
  assign is_mul   = (SELECT[5:2] == 4'b0010);
  assign is_div   = (SELECT[5:2] == 4'b0011);
  assign sgn      = ~SELECT[0];
  assign div_zero = (DATA2 == '0);
  assign div_ovf  = sgn & (DATA1 == MIN_NEG) & (DATA2 == '1);
  assign fast_res = div_zero ? (SELECT[1] ? DATA1 : '1)
                             : (SELECT[1] ? '0 : DATA1);
  assign a_mag = (sgn & DATA1[XLEN-1]) ? -DATA1 : DATA1;
  assign b_mag = (sgn & DATA2[XLEN-1]) ? -DATA2 : DATA2;

  logic mc_sx;
  assign mc_sx = (SELECT[1:0] == 2'b01) | (SELECT[1:0] == 2'b10);

  // Signed multiplier: unsigned sum of its bits minus multiplicand<<XLEN
  logic [2*XLEN-1:0] part, acc_nxt, prod;
  always_comb begin
    part = '0;
    for (int i = 0; i < MUL_BITS; i++)
      if (mplier[i]) part = part + (mcand << i);
    acc_nxt = acc + part;
    prod    = mplier_neg ? acc_nxt - (mcand << MUL_BITS) : acc_nxt;
  end

  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN-1:0] rem_nxt, quo_nxt, q_fin, r_fin;
  always_comb begin
    trial   = {rem, quo[XLEN-1]};
    ge      = trial >= {1'b0, dvsr};
    rem_nxt = ge ? XLEN'(trial - {1'b0, dvsr}) : trial[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], ge};
    q_fin   = neg_q ? -quo_nxt : quo_nxt;
    r_fin   = neg_r ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      RESULT     <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      mul_hi     <= 1'b0;
      mplier_neg <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      dvsr       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      is_rem     <= 1'b0;
    end else if (FLUSH) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (IN_VALID) begin
          cnt <= '0;
          if (is_mul) begin
            mcand      <= {{XLEN{mc_sx & DATA1[XLEN-1]}}, DATA1};
            mplier     <= DATA2;
            acc        <= '0;
            mul_hi     <= (SELECT[1:0] != 2'b00);
            mplier_neg <= (SELECT[1:0] == 2'b01) & DATA2[XLEN-1];
            state      <= MUL;
          end else if (is_div) begin
            if (div_zero | div_ovf) begin
              RESULT <= fast_res;
              state  <= DONE;
            end else begin
              quo    <= a_mag;
              dvsr   <= b_mag;
              rem    <= '0;
              neg_q  <= sgn & (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
              neg_r  <= sgn & DATA1[XLEN-1];
              is_rem <= SELECT[1];
              state  <= DIV;
            end
          end else begin
            RESULT <= base;
            state  <= DONE;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          cnt    <= cnt + 1'b1;
          if (cnt == MUL_LAST) begin
            RESULT <= mul_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
            cnt    <= '0;
            state  <= DONE;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == DIV_LAST) begin
            RESULT <= is_rem ? r_fin : q_fin;
            cnt    <= '0;
            state  <= DONE;
          end
        end
        DONE: if (OUT_READY) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq: random and directed ops vs a
// plain-arithmetic reference; a second instance covers MUL_BITS=4.
`timescale 1ns/1ps
module tb_alu_mdu_seq;
  logic        clk = 0;
  logic        rst = 1;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] data1 = 0, data2 = 0;
  logic [5:0]  sel = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] result;
  logic        busy;

  logic        v4 = 0, r4, ov4, b4;
  logic [31:0] a4 = 0, d4 = 0, res4;
  logic [5:0]  s4 = 0;

  always #5 clk = ~clk;

  alu_mdu_seq #(.XLEN(32), .MUL_BITS(1)) dut (
    .CLK(clk), .RESET(rst), .FLUSH(flush),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .DATA1(data1), .DATA2(data2), .SELECT(sel),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .RESULT(result), .BUSY(busy));

  alu_mdu_seq #(.XLEN(32), .MUL_BITS(4)) dut4 (
    .CLK(clk), .RESET(rst), .FLUSH(1'b0),
    .IN_VALID(v4), .IN_READY(r4),
    .DATA1(a4), .DATA2(d4), .SELECT(s4),
    .OUT_VALID(ov4), .OUT_READY(1'b1),
    .RESULT(res4), .BUSY(b4));

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    logic [5:0]  sel;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0, cyc = 0;
  bit hold = 0, rnd = 0, ov_prev = 0;
  logic [31:0] held;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = hold ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(logic [5:0] s, logic [31:0] a,
                                          logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic signed [31:0] t;
    bit ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (s[5:3] == 3'b011) return b;
    case (s)
      6'd0:  return a + b;
      6'd1:  return a << b[4:0];
      6'd2:  return {31'b0, sa < sb};
      6'd3:  return {31'b0, a < b};
      6'd4:  return a ^ b;
      6'd5:  return a >> b[4:0];
      6'd6:  return a | b;
      6'd7:  return a & b;
      6'd8:  begin p = ua * ub; return p[31:0]; end
      6'd9:  begin p = sa * sb; return p[63:32]; end
      6'd10: begin p = sa * longint'(ub); return p[63:32]; end
      6'd11: begin p = ua * ub; return p[63:32]; end
      6'd12: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      6'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      6'd14: begin
        if (b == 0) return a;
        if (ovf) return 0;
        return 32'(sa % sb);
      end
      6'd15: return (b == 0) ? a : a % b;
      6'd16: return a - b;
      6'd21: begin t = $signed(a); t = t >>> b[4:0]; return t; end
      default: return 0;
    endcase
  endfunction

  function automatic int ref_lat(logic [5:0] s, logic [31:0] a,
                                 logic [31:0] b);
    if (s >= 6'd8 && s <= 6'd11) return 33;
    if (s >= 6'd12 && s <= 6'd15) begin
      if (b == 0) return 1;
      if (!s[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return 1;
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        if (!ov_prev) begin
          chk($sformatf("latency_sel%0d", q[0].sel), cyc - q[0].acc, q[0].lat);
          held = result;
        end else begin
          chk("held_result", result, held);
        end
        chk("in_ready_in_done", {31'b0, in_ready}, 32'd0);
        if (out_ready) begin
          chk($sformatf("result_sel%0d", q[0].sel), result, q[0].res);
          void'(q.pop_front());
        end
      end
    end else if (ov_prev) begin
      chk("out_valid_dropped", 32'd0, 32'd1);
    end
    ov_prev = out_valid && !out_ready;
  end

  task automatic issue(logic [5:0] s, logic [31:0] a, logic [31:0] b);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1;
    sel = s;
    data1 = a;
    data2 = b;
    e.res = ref_res(s, a, b);
    e.lat = ref_lat(s, a, b);
    e.acc = cyc;
    e.sel = s;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 0;
    data1 = $urandom;
    data2 = $urandom;
    sel = 6'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || busy) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] sp [5];
    sp[0] = 0; sp[1] = 1; sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic run4(logic [5:0] s, logic [31:0] a, logic [31:0] b,
                      logic [31:0] exp, string nm);
    int n;
    @(negedge clk);
    if (!r4) @(negedge clk);
    v4 = 1; s4 = s; a4 = a; d4 = b;
    @(posedge clk);
    #1 v4 = 0; a4 = $urandom;
    for (n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (ov4) break;
    end
    chk({nm, "_mb4_latency"}, n, 9);
    chk({nm, "_mb4_result"}, res4, exp);
  endtask

  logic [5:0] codes [20];
  initial begin
    int seen;
    for (int i = 0; i < 8; i++) codes[i] = 6'(i);
    for (int i = 8; i < 16; i++) codes[i] = 6'(i);
    codes[16] = 6'd16; codes[17] = 6'd21;
    codes[18] = 6'b011010; codes[19] = 6'b100011;

    #2;
    chk("reset_result", result, 0);
    chk("reset_out_valid", {31'b0, out_valid}, 0);
    chk("reset_in_ready", {31'b0, in_ready}, 1);
    chk("reset_busy", {31'b0, busy}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    issue(6'd0, 5, 7);
    issue(6'd21, 32'h8000_0000, 33);
    issue(6'b011101, 0, 32'hABCD);
    issue(6'b111111, 32'h1234, 32'h5678);
    issue(6'd9, 32'h8000_0000, 32'h8000_0000);
    issue(6'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(6'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(6'd8, 32'h10000, 32'h10000);
    issue(6'd12, -32'sd7, 2);
    issue(6'd14, -32'sd7, 2);
    issue(6'd13, 100, 0);
    issue(6'd15, 100, 0);
    issue(6'd12, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(6'd14, 32'h8000_0000, 32'hFFFF_FFFF);
    drain();

    hold = 1;
    issue(6'd13, 1000, 7);
    repeat (10) @(negedge clk) data1 = $urandom;
    seen = 0;
    for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
    repeat (5) @(negedge clk) if (out_valid) seen++;
    chk("bp_valid_cycles", seen, 5);
    hold = 0;
    drain();

    issue(6'd12, 12345, 67);
    repeat (10) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 1);
    q.delete();
    @(negedge clk);
    rst = 0;
    issue(6'd0, 1, 1);
    drain();

    issue(6'd8, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1;
    q.delete();
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    chk("flush_in_ready", {31'b0, in_ready}, 1);
    seen = 0;
    repeat (40) @(negedge clk) if (out_valid) seen++;
    chk("flush_no_out_valid", seen, 0);

    @(negedge clk);
    in_valid = 1; flush = 1; sel = 6'd0; data1 = 3; data2 = 4;
    @(posedge clk);
    #1 in_valid = 0; flush = 0;
    @(negedge clk);
    chk("flush_blocks_accept", {31'b0, busy}, 0);
    seen = 0;
    repeat (3) @(negedge clk) if (out_valid) seen++;
    chk("flush_accept_no_out", seen, 0);

    rnd = 1;
    for (int i = 0; i < 150; i++)
      issue(codes[$urandom_range(0, 19)], pick_operand(), pick_operand());
    drain();
    rnd = 0;

    run4(6'd9, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
    run4(6'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    run4(6'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run4(6'd8, 32'h10000, 32'h10000, 32'h0, "mul");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
Parametrised XLEN-wide successor to the combinational RV32IM ALU. Base RV32I ops complete in one registered cycle. M-extension multiply and divide run on iterative shift-add and restoring-divide datapaths. Valid/ready handshakes on both the operand side and the result side let the EX stage stall on long ops instead of carrying a 64-bit combinational multiplier and divider. Full RISC-V semantics: correct MULH* high-word slice, div-by-zero and overflow results, shift amount masked to log2(XLEN) bits.

Parameters:
XLEN, 32, operand/result width; power of 2, at least 8.
MUL_BITS, 1, multiplier bits retired per cycle; one of 1, 2, 4; must divide XLEN.

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
FLUSH  input  1  synchronous abort of the in-flight op (pipeline flush).
IN_VALID  input  1  operands and SELECT valid.
IN_READY  output  1  unit accepts an op this cycle.
DATA1  input  XLEN  operand 1 (rs1).
DATA2  input  XLEN  operand 2 (rs2 or imm).
SELECT  input  6  op code; same encoding as the existing ALU: 000000 ADD, 000001 SLL, 000010 SLT, 000011 SLTU, 000100 XOR, 000101 SRL, 000110 OR, 000111 AND, 001000 MUL, 001001 MULH, 001010 MULHSU, 001011 MULHU, 001100 DIV, 001101 DIVU, 001110 REM, 001111 REMU, 010000 SUB, 010101 SRA, 011xxx FWD (DATA2); anything else gives 0.
OUT_VALID  output  1  RESULT valid.
OUT_READY  input  1  consumer takes RESULT.
RESULT  output  XLEN  registered result.
BUSY  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, MUL, DIV, DONE. IN_READY = (state==IDLE). Accept = IN_VALID & IN_READY.
- Reset, asynchronous: state IDLE, OUT_VALID 0, RESULT 0, BUSY 0, IN_READY 1, all iteration counters and accumulators 0. Applies at any point, including mid-MUL or mid-DIV; no partial result is ever emitted.
- Base ops, FWD and undefined codes: on accept, RESULT is registered and state goes to DONE. OUT_VALID is high the cycle after accept (latency 1).
- Shifts: shamt = DATA2[log2(XLEN)-1:0]. SRA is sign-filling. SLT/SLTU produce zero-extended 0/1.
- MUL family, on accept:
  - Latch operands; MULH/MULHSU sign-extend to 2*XLEN as required; go to MUL.
  - Each cycle retires MUL_BITS of multiplier into a 2*XLEN accumulator.
  - After XLEN/MUL_BITS cycles, RESULT = product[XLEN-1:0] for MUL, else product[2*XLEN-1:XLEN]; go to DONE.
  - Latency = XLEN/MUL_BITS + 1 cycles from accept to OUT_VALID.
- DIV family, on accept:
  - Fast path, latency 1, straight to DONE:
    - Divisor 0: DIV/DIVU give all-ones; REM/REMU give DATA1.
    - Signed overflow (DATA1 = most-negative, DATA2 = all-ones): DIV gives DATA1; REM gives 0.
  - Otherwise go to DIV: restoring divide on magnitudes, 1 quotient bit per cycle, XLEN cycles.
  - Sign fix-up for signed ops: quotient negated if operand signs differ; remainder takes the sign of DATA1.
  - Latency = XLEN + 1 cycles.
- DONE:
  - OUT_VALID = 1. RESULT is held stable while OUT_READY = 0 (backpressure for any length).
  - OUT_READY = 1 goes to IDLE; OUT_VALID drops the next cycle. A new op is accepted no earlier than the cycle after that. No back-to-back accept from DONE.
- FLUSH:
  - In any state, next state IDLE, OUT_VALID 0, counters cleared; RESULT value is don't-care.
  - FLUSH in the same cycle as IN_VALID in IDLE: flush wins and the op is not accepted.
- DATA1, DATA2 and SELECT are sampled only on accept; later changes while BUSY have no effect.

Test Plan:
- XLEN=32. ADD 5+7, OUT_READY=1 -> OUT_VALID 1 cycle after accept, RESULT=12. Then SRA 0x80000000 by 33 -> 0xC0000000. Then SELECT 011101 with DATA2=0xABCD -> 0xABCD. Then SELECT 111111 -> 0.
- MUL_BITS=1. MULH 0x80000000*0x80000000 -> 0x40000000 at 33 cycles. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MUL 0x10000*0x10000 -> 0. Repeat with MUL_BITS=4 -> 9-cycle latency.
- DIV -7/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF at 33 cycles. DIVU 100/0 -> 0xFFFFFFFF and REMU -> 100 at 1 cycle. DIV 0x80000000/-1 -> 0x80000000 and REM -> 0 at 1 cycle.
- Backpressure: hold OUT_READY=0 for 5 cycles after a DIVU result -> RESULT stable, OUT_VALID 1, IN_READY 0 throughout. Change DATA1 during the op -> result unaffected.
- RESET pulse (asynchronous, mid-cycle) 10 cycles into a DIV -> OUT_VALID 0 and IN_READY 1 immediately. Next ADD 1+1 -> 2.
- FLUSH 5 cycles into a MUL -> IN_READY 1 next cycle and no OUT_VALID pulse. FLUSH with IN_VALID in IDLE -> op not accepted.
